// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the mult/div sequencer state type.
// The ALU and the decoder reuse the same opcode/funct values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Absolute value when the operand is treated as signed, pass-through otherwise.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the mult/div sequencer.
// The pipeline drives the instruction and operands; the sequencer answers with stall and HI/LO.
interface muldiv_sequencer_if;

  logic [31:0] inst;
  logic [31:0] oprand1;
  logic [31:0] oprand2;
  logic        hold;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hilo_out;

  modport master (
    output inst, oprand1, oprand2, hold, flush,
    input  stall, busy, hi, lo, hilo_out
  );

  modport slave (
    input  inst, oprand1, oprand2, hold, flush,
    output stall, busy, hi, lo, hilo_out
  );

endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle iteration engine: shift-add multiply or restoring divide on magnitudes.
// Multiply leaves the product in acc; divide leaves {remainder, quotient}.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] acc_o,
  output logic        last_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [4:0]  count_q, count_d;
  logic        mode_q, mode_d;
  logic [32:0] sum;
  logic [32:0] diff;

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  // Divide: trial subtract of the divisor from the shifted partial remainder.
  assign diff = acc_q[63:31] - {1'b0, opnd_q};

  always_comb begin
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    count_d = count_q;
    mode_d  = mode_q;
    if (start_i) begin
      acc_d   = is_div_i ? {32'd0, a_i} : {32'd0, b_i};
      opnd_d  = is_div_i ? b_i : a_i;
      mode_d  = is_div_i;
      count_d = 5'd0;
    end else if (step_i) begin
      count_d = count_q + 5'd1;
      if (mode_q) begin
        acc_d = diff[32] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
      end else begin
        acc_d = {sum, acc_q[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      count_q <= 5'd0;
      mode_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (count_q == 5'd31);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div/divu controller owning HI/LO; stalls dependent or conflicting
// instructions while an operation is in flight and serves mfhi/mflo through hilo_out.
module muldiv_sequencer
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, hilo_q, hilo_d;
  logic        is_div_q, is_div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  logic        is_rtype, dec_mult, dec_div, dec_divu, dec_mfhi, dec_mflo, dec_any;
  logic        signed_op, div_zero, busy, stall, consumed, start, last;
  logic [31:0] mag_a, mag_b, quo, rem;
  logic [63:0] acc, prod;
  logic        unused_inst;

  assign is_rtype  = (bus.inst[31:26] == OP_RTYPE);
  assign dec_mult  = is_rtype && (bus.inst[5:0] == FN_MULT);
  assign dec_div   = is_rtype && (bus.inst[5:0] == FN_DIV);
  assign dec_divu  = is_rtype && (bus.inst[5:0] == FN_DIVU);
  assign dec_mfhi  = is_rtype && (bus.inst[5:0] == FN_MFHI);
  assign dec_mflo  = is_rtype && (bus.inst[5:0] == FN_MFLO);
  assign dec_any   = dec_mult | dec_div | dec_divu | dec_mfhi | dec_mflo;
  assign unused_inst = ^bus.inst[25:6];

  assign busy      = (state_q != IDLE);
  assign stall     = dec_any & busy & ~bus.flush;
  assign consumed  = dec_any & ~bus.hold & ~bus.flush & ~stall;
  assign signed_op = dec_mult | dec_div;
  assign div_zero  = (dec_div | dec_divu) && (bus.oprand2 == 32'd0);
  assign mag_a     = magnitude(bus.oprand1, signed_op);
  assign mag_b     = magnitude(bus.oprand2, signed_op);

  muldiv_iter_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .step_i   (state_q == RUN),
    .is_div_i (dec_div | dec_divu),
    .a_i      (mag_a),
    .b_i      (mag_b),
    .acc_o    (acc),
    .last_o   (last)
  );

  // neg_q covers both the product sign (mult) and the quotient sign (div).
  assign prod = neg_q_q ? (~acc + 64'd1) : acc;
  assign quo  = neg_q_q ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem  = neg_r_q ? (~acc[63:32] + 32'd1) : acc[63:32];

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hilo_d   = hilo_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    case (state_q)
      IDLE: begin
        if (consumed) begin
          if (dec_mfhi) begin
            hilo_d = hi_q;
          end else if (dec_mflo) begin
            hilo_d = lo_q;
          end else if (div_zero) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = bus.oprand1;
          end else begin
            start    = 1'b1;
            state_d  = RUN;
            is_div_d = dec_div | dec_divu;
            neg_q_d  = signed_op & (bus.oprand1[31] ^ bus.oprand2[31]);
            neg_r_d  = dec_div & bus.oprand1[31];
          end
        end
      end
      RUN: begin
        if (last) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (is_div_q) begin
          lo_d = quo;
          hi_d = rem;
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hilo_q   <= 32'd0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hilo_q   <= hilo_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign bus.stall    = stall;
  assign bus.busy     = busy;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.hilo_out = hilo_q;

endmodule
